cmp_arbiter: RTL

Shares one `cmp` branch comparator between two requesters, the branch unit (requester 0) and a second port such as a set-less-than helper (requester 1), using round-robin arbitration. It registers the operands and the per-requester results, which gives a fixed 2-cycle latency and a total throughput of one compare per cycle. Each requester sees a valid/ready request channel and a valid/ready response channel.

---
 rtl/rv32i_types.sv | 37 +++
 rtl/cmp.sv | 28 ++
 rtl/cmp_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types for the branch-compare path: funct3 encodings and the
// request/response records held by the shared comparator arbiter.
package rv32i_types;

  localparam int CMP_TAG_W = 4;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  // Identifies which requester owns an in-flight compare.
  typedef logic owner_t;

  // Operand-stage contents.
  typedef struct packed {
    logic                 valid;
    owner_t               owner;
    branch_funct3_t       op;
    logic [31:0]          a;
    logic [31:0]          b;
    logic [CMP_TAG_W-1:0] tag;
  } cmp_req_t;

  // Per-requester result-stage contents.
  typedef struct packed {
    logic                 valid;
    logic                 taken;
    logic                 illegal;
    logic [CMP_TAG_W-1:0] tag;
  } cmp_resp_t;

endpackage

// File: rtl/cmp.sv
// Branch comparator: purely combinational RV32I branch condition evaluation.
// Encodings 010/011 are not branches and are flagged illegal with taken low.
module cmp
  import rv32i_types::*;
(
  input  branch_funct3_t op,
  input  logic [31:0]    a,
  input  logic [31:0]    b,
  output logic           taken,
  output logic           illegal
);

  // Decode funct3 and evaluate the matching signed/unsigned condition.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (op)
      beq:     taken = (a == b);
      bne:     taken = (a != b);
      blt:     taken = ($signed(a) <  $signed(b));
      bge:     taken = ($signed(a) >= $signed(b));
      bltu:    taken = (a <  b);
      bgeu:    taken = (a >= b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin sharing of one branch comparator between two requesters.
// An operand register (S1) feeds the comparator, whose outcome lands in a
// per-requester result register, giving a fixed two-cycle latency.
module cmp_arbiter
  import rv32i_types::*;
#(
  parameter int TAG_W = CMP_TAG_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic           [1:0]        req_valid,
  output logic           [1:0]        req_ready,
  input  branch_funct3_t [1:0]        req_op,
  input  logic           [1:0][31:0]  req_a,
  input  logic           [1:0][31:0]  req_b,
  input  logic           [1:0][TAG_W-1:0] req_tag,
  output logic           [1:0]        resp_valid,
  input  logic           [1:0]        resp_ready,
  output logic           [1:0]        resp_taken,
  output logic           [1:0]        resp_illegal,
  output logic           [1:0][TAG_W-1:0] resp_tag,
  output logic                        busy
);

  cmp_req_t             s1;
  cmp_resp_t [1:0]      r;
  logic                 rr;
  logic      [1:0]      grant;
  logic      [1:0]      pop;
  logic      [1:0]      fill;
  logic                 s1_move;
  logic                 s1_free;
  logic                 accept;
  owner_t               sel;
  logic                 cmp_taken;
  logic                 cmp_illegal;

  cmp u_cmp (
    .op      (s1.op),
    .a       (s1.a),
    .b       (s1.b),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  // Grant, stage-advance and handshake decisions for the current cycle.
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) begin
      grant = rr ? 2'b10 : 2'b01;
    end else begin
      grant = req_valid;
    end
    s1_move   = s1.valid && (!r[s1.owner].valid || resp_ready[s1.owner]);
    s1_free   = !s1.valid || s1_move;
    req_ready = rst_n ? (grant & {2{s1_free}}) : 2'b00;
    accept    = |(req_valid & req_ready);
    sel       = req_ready[1];
    pop       = 2'b00;
    fill      = 2'b00;
    for (int i = 0; i < 2; i++) begin
      pop[i]  = r[i].valid && resp_ready[i];
      fill[i] = s1_move && (s1.owner == owner_t'(i));
    end
  end

  // Operand stage and round-robin pointer; the pointer only moves on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      rr <= 1'b0;
    end else if (accept) begin
      s1.valid <= 1'b1;
      s1.owner <= sel;
      s1.op    <= req_op[sel];
      s1.a     <= req_a[sel];
      s1.b     <= req_b[sel];
      s1.tag   <= req_tag[sel];
      rr       <= ~sel;
    end else if (s1_move) begin
      s1.valid <= 1'b0;
    end
  end

  // Result registers; a fill in the same edge as a pop replaces the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fill[i]) begin
          r[i].valid   <= 1'b1;
          r[i].taken   <= cmp_taken;
          r[i].illegal <= cmp_illegal;
          r[i].tag     <= s1.tag;
        end else if (pop[i]) begin
          r[i].valid <= 1'b0;
        end
      end
    end
  end

  // Result registers drive the response channels directly.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      resp_valid[i]   = r[i].valid;
      resp_taken[i]   = r[i].taken;
      resp_illegal[i] = r[i].illegal;
      resp_tag[i]     = r[i].tag;
    end
    busy = s1.valid | r[0].valid | r[1].valid;
  end

endmodule
